// File: rtl/sram_req_ctrl_pkg.sv
// Shared types and constants for the SRAM request controller.
//   rsp_entry_t : response FIFO payload {rdata, is_write}
//   STAT_W      : width of the saturating statistic counters
//   num_bytes() : byte lanes in a data word
package sram_req_ctrl_pkg;

  localparam int unsigned STAT_W     = 16;
  localparam int unsigned RSP_DATA_W = 32;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] rdata;
    logic                  is_write;
  } rsp_entry_t;

  function automatic int unsigned num_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous FIFO of response entries.
//   clk, rst  : clock, async active-high reset (pointers/count only)
//   push_i    : write data_i (ignored when full unless popping)
//   pop_i     : remove head (ignored when empty)
//   count_o   : occupancy
//   head_o    : oldest entry
module sram_rsp_fifo
  import sram_req_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  rsp_entry_t       data_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output rsp_entry_t       head_o
);

  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;
  rsp_entry_t       mem_q [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Push and pop in the same cycle is allowed even at full
  always_comb begin
    do_pop  = pop_i & (cnt_q != '0);
    do_push = push_i & ((cnt_q != CNT_W'(DEPTH)) | do_pop);
    wr_d    = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d    = do_pop ? ptr_inc(rd_q) : rd_q;
    cnt_d   = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; the top masks the head while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/sram_req_ctrl.sv
// Request/response front-end for a single-port synchronous SRAM.
// Requests (valid/ready) drive the SRAM pins combinationally; the SRAM's
// one-cycle-late read data lands in a credit-protected response FIFO.
//   clk, rst           : clock, async active-high reset
//   req_*              : request channel (req_we all-zero = read)
//   rsp_*              : response channel, in request order
//   sram_*             : SRAM macro pins
//   stat_rd/wr_cnt     : saturating accepted-request counters
// Build option SRAM_REQ_CTRL_WRITE_RSP_EN: writes also take a credit and
// return a {rdata=0, is_write=1} response.
module sram_req_ctrl
  import sram_req_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RSP_DATA_W,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RSP_DEPTH  = 4,
  localparam int unsigned NB = num_bytes(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [NB-1:0]         req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_is_write,
  output logic                  sram_en,
  output logic [NB-1:0]         sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic [STAT_W-1:0]     stat_rd_cnt,
  output logic [STAT_W-1:0]     stat_wr_cnt
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
`ifdef SRAM_REQ_CTRL_WRITE_RSP_EN
  localparam bit WR_RSP = 1'b1;
`else
  localparam bit WR_RSP = 1'b0;
`endif

  logic              is_rd, needs_credit, credit_ok, fire, pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              pend_q, pend_d, pend_wr_q, pend_wr_d;
  logic [STAT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  rsp_entry_t        push_entry, head;

  // Credit check uses registered state only (FIFO count + access in flight)
  always_comb begin
    is_rd        = (req_we == '0);
    needs_credit = is_rd | WR_RSP;
    credit_ok    = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(pend_q)) < (CNT_W+1)'(RSP_DEPTH);
    req_ready    = !rst && (credit_ok || !needs_credit);
    fire         = req_valid & req_ready;
  end

  assign sram_en   = fire;
  assign sram_we   = req_we & {NB{fire}};
  assign sram_addr = req_addr;
  assign sram_din  = req_wdata;

  // Track the access whose response is captured next cycle; stats saturate
  always_comb begin
    pend_d    = fire & needs_credit;
    pend_wr_d = fire & ~is_rd;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    if (fire && is_rd && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + STAT_W'(1);
    if (fire && !is_rd && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= 1'b0;
      pend_wr_q <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // SRAM read-during-write output is discarded for write responses
  always_comb begin
    push_entry.rdata    = pend_wr_q ? '0 : sram_dout;
    push_entry.is_write = pend_wr_q;
  end

  assign pop = rsp_valid & rsp_ready;

  sram_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pend_q),
    .data_i  (push_entry),
    .pop_i   (pop),
    .count_o (fifo_count),
    .head_o  (head)
  );

  // Head is masked while empty so stale storage never shows on rsp_*
  assign rsp_valid    = (fifo_count != '0);
  assign rsp_rdata    = rsp_valid ? head.rdata : '0;
  assign rsp_is_write = rsp_valid & head.is_write & WR_RSP;
  assign stat_rd_cnt  = rd_cnt_q;
  assign stat_wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_sram_req_ctrl.sv
module tb_sram_req_ctrl;

  localparam int DEPTH = 4;
`ifdef SRAM_REQ_CTRL_WRITE_RSP_EN
  localparam bit WR_RSP = 1'b1;
`else
  localparam bit WR_RSP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_we = '0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_is_write;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout = '0;
  logic [15:0] stat_rd_cnt, stat_wr_cnt;

  always #5 clk = ~clk;

  sram_req_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_is_write(rsp_is_write),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout),
    .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
  );

  // SRAM macro model: registered read, byte-masked write, junk on write cycles
  logic [31:0] smem [1024];
  always @(posedge clk) begin
    if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) smem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
      if (sram_we == '0) sram_dout <= smem[sram_addr];
      else               sram_dout <= $urandom;
    end
  end

  // Reference model: memory image plus queue of owed responses in order
  typedef struct { logic [31:0] d; bit w; int cyc; } exp_t;
  exp_t        q[$];
  logic [31:0] mmem [1024];
  int          m_rd, m_wr, cyc;
  int          checks = 0, errors = 0;
  logic        s_ready, s_valid, s_iw;
  logic [31:0] s_rdata;
  int          dut_fires, dut_pops, first_pop, last_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] we, input logic [9:0] a,
                      input logic [31:0] d, input logic rr);
    logic exp_ready, exp_rv;
    @(posedge clk); #1;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
    @(negedge clk);
    s_ready = req_ready; s_valid = rsp_valid; s_rdata = rsp_rdata; s_iw = rsp_is_write;
    exp_ready = ((we == 4'h0) || WR_RSP) ? (q.size() < DEPTH) : 1'b1;
    exp_rv    = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
    chk("req_ready", req_ready, 32'(exp_ready));
    chk("rsp_valid", rsp_valid, 32'(exp_rv));
    if (exp_rv && rsp_valid) begin
      chk("rsp_rdata", rsp_rdata, q[0].d);
      chk("rsp_is_write", 32'(rsp_is_write), 32'(q[0].w));
    end
    chk("stat_rd_cnt", 32'(stat_rd_cnt), 32'(m_rd));
    chk("stat_wr_cnt", 32'(stat_wr_cnt), 32'(m_wr));
    if (v && req_ready) dut_fires++;
    if (rsp_valid && rr) begin
      if (dut_pops == 0) first_pop = cyc;
      last_pop = cyc;
      dut_pops++;
    end
    if (exp_rv && rr) void'(q.pop_front());
    if (v && exp_ready) begin
      if (we == 4'h0) begin
        q.push_back('{d: mmem[a], w: 1'b0, cyc: cyc});
        if (m_rd < 16'hFFFF) m_rd++;
      end else begin
        for (int b = 0; b < 4; b++) if (we[b]) mmem[a][b*8 +: 8] = d[b*8 +: 8];
        if (WR_RSP) q.push_back('{d: 32'h0, w: 1'b1, cyc: cyc});
        if (m_wr < 16'hFFFF) m_wr++;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 10'h0, 32'h0, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; req_we = '0;
    q.delete(); m_rd = 0; m_wr = 0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_stat_rd", 32'(stat_rd_cnt), 32'h0);
    chk("rst_stat_wr", 32'(stat_wr_cnt), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_sram_en", 32'(sram_en), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic v; logic [3:0] we; logic [9:0] a; logic [31:0] d; logic rr;
    logic er; logic ev; logic [31:0] ed; logic ew;
  } vec_t;
  vec_t tbl [8];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      smem[i] = 32'(i) * 32'h9E3779B1;
      mmem[i] = 32'(i) * 32'h9E3779B1;
    end
    m_rd = 0; m_wr = 0; cyc = 0;

    // Table: full write, RAW read, full write, partial merge, read back
    tbl[0] = '{1'b1, 4'hF, 10'h005, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0,   32'h0,        1'b0};
    tbl[1] = '{1'b1, 4'h0, 10'h005, 32'h0,        1'b1, 1'b1, 1'b0,   32'h0,        1'b0};
    tbl[2] = '{1'b1, 4'hF, 10'h010, 32'h11223344, 1'b1, 1'b1, WR_RSP, 32'h0,        1'b1};
    tbl[3] = '{1'b1, 4'h2, 10'h010, 32'h0000AA00, 1'b1, 1'b1, 1'b1,   32'hDEADBEEF, 1'b0};
    tbl[4] = '{1'b1, 4'h0, 10'h010, 32'h0,        1'b1, 1'b1, WR_RSP, 32'h0,        1'b1};
    tbl[5] = '{1'b0, 4'h0, 10'h000, 32'h0,        1'b1, 1'b1, WR_RSP, 32'h0,        1'b1};
    tbl[6] = '{1'b0, 4'h0, 10'h000, 32'h0,        1'b1, 1'b1, 1'b1,   32'h1122AA44, 1'b0};
    tbl[7] = '{1'b0, 4'h0, 10'h000, 32'h0,        1'b1, 1'b1, 1'b0,   32'h0,        1'b0};

    #3;
    chk("init_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("init_req_ready", 32'(req_ready), 32'h0);
    chk("init_stat_rd", 32'(stat_rd_cnt), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rr);
      chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_rdata", i), s_rdata, tbl[i].ed);
        chk($sformatf("tbl%0d_is_write", i), 32'(s_iw), 32'(tbl[i].ew));
      end
    end
    chk("tbl_stat_rd", 32'(stat_rd_cnt), 32'd2);
    chk("tbl_stat_wr", 32'(stat_wr_cnt), 32'd3);

    // 16 back-to-back reads with rsp_ready held high
    dut_fires = 0; dut_pops = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 4'h0, 10'(i + 32), 32'h0, 1'b1);
    chk("b2b_fires", 32'(dut_fires), 32'd16);
    idle(4);
    chk("b2b_pops", 32'(dut_pops), 32'd16);
    chk("b2b_consecutive", 32'(last_pop - first_pop), 32'd15);

    // Back-pressure: exactly DEPTH accepted, ready returns the cycle after a pop
    dut_fires = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 4'h0, 10'(i + 64), 32'h0, 1'b0);
    chk("bp_accepted", 32'(dut_fires), 32'(DEPTH));
    step(1'b1, 4'h0, 10'h050, 32'h0, 1'b1);
    chk("bp_ready_at_pop", 32'(s_ready), 32'h0);
    step(1'b1, 4'h0, 10'h051, 32'h0, 1'b1);
    chk("bp_ready_after_pop", 32'(s_ready), 32'h1);
    idle(8);

    // Reset with two responses queued and one read in flight
    for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 10'(i + 96), 32'h0, 1'b0);
    do_reset();
    dut_pops = 0;
    idle(5);
    chk("post_rst_no_stale", 32'(dut_pops), 32'h0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [3:0] we;
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      step(1'($urandom_range(0, 3) != 0), we, 10'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 2) != 0));
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
